match_scorer: RTL
=================

MATCH_SCORER -- requirements
Module: match_scorer

Interface
REQ-001 SHALL have parameter DEPTH, default 3, positions per side excluding neutral (legal 1..7).
REQ-002 SHALL have parameter GAMES_TO_WIN, default 2, games one player must win to take the match (legal 1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port winrnd  input  1  one-cycle pulse: a push occurred.
REQ-006 SHALL have port right  input  1  1 = right player pushed first, 0 = left.
REQ-007 SHALL have port leds_on  input  1  1 = push was proper (lights on), 0 = jumped the light.
REQ-008 SHALL have port new_game  input  1  one-cycle pulse: start the next game.
REQ-009 SHALL have port score  output  2*DEPTH+1  LED bar, MSB = leftmost position, bit DEPTH = neutral.
REQ-010 SHALL have port games_l / games_r  output  4 each  games won per player.
REQ-011 SHALL have port win_l / win_r  output  1 each  one-cycle pulse when a game is won.
REQ-012 SHALL have port match_over  output  1  high while the match is decided.

Function
REQ-013 SHALL hold a signed position pos in -DEPTH..+DEPTH (negative = left) and a state in {PLAY, GAME_WON, MATCH_OVER}.
REQ-014 SHALL compute mr = (right & leds_on) | (~right & ~leds_on): a proper right push or an improper left push moves right.
REQ-015 In PLAY, on winrnd, SHALL set pos+1 if mr, else pos-1.
REQ-016 In PLAY, a move from pos=+DEPTH with mr SHALL enter GAME_WR: pos unchanged, games_r+1, win_r pulses the next cycle; the left case is symmetric (games_l, win_l).
REQ-017 On a game win, if the winner's new count equals GAMES_TO_WIN the state SHALL become MATCH_OVER, else GAME_WON.
REQ-018 In GAME_WON, winrnd SHALL be ignored; new_game SHALL set pos=0 and state PLAY on the next edge.
REQ-019 In PLAY, new_game SHALL abort the game (pos=0, no count change), taking priority over a simultaneous winrnd.
REQ-020 In MATCH_OVER, winrnd and new_game SHALL be ignored; only rst exits.
REQ-021 In PLAY, score SHALL be one-hot with bit (DEPTH - pos) set.
REQ-022 In GAME_WON/MATCH_OVER, score SHALL have bits [2*DEPTH:DEPTH+1] all set for a left win or [DEPTH-1:0] all set for a right win, all other bits 0.
REQ-023 score and match_over SHALL decode combinationally from registered state; win_l/win_r SHALL be registered.
REQ-024 Any unreachable state encoding SHALL drive score to alternating 1010... from the MSB and return to PLAY with pos=0 on the next edge.

Reset
REQ-025 rst SHALL asynchronously force pos=0, state PLAY, games_l=games_r=0, win_l=win_r=0, and score = neutral only (bit DEPTH).
REQ-026 rst asserted mid-game or mid-match SHALL discard all progress; the first winrnd after rst deasserts SHALL be honoured.

Configuration
REQ-027 With FAVOR_LOSER_EN defined, a proper push (leds_on=1) by the trailing player at |pos|=DEPTH SHALL set pos to +1 or -1 (leader's side) instead of stepping by one; improper pushes always step by one.
REQ-028 Without FAVOR_LOSER_EN, every move in PLAY SHALL step pos by exactly one.

Verification
REQ-029 Use DEPTH=3, GAMES_TO_WIN=2: rst, then 4 proper right pushes -> score 0001000, 0000100, 0000010, 0000001, then 0000111; win_r one pulse; games_r=1.
REQ-030 From neutral, improper left push (right=0, leds_on=0) -> score 0000100 (moves right).
REQ-031 FAVOR_LOSER_EN, pos=-3 (1000000), proper right push -> 0010000; without the macro -> 0100000.
REQ-032 Win two right games with new_game between -> match_over=1, games_r=2; further winrnd/new_game leave score 0000111.
REQ-033 PLAY at pos=+2 with winrnd and new_game in the same cycle -> score 0001000, counts unchanged.
REQ-034 rst pulsed in GAME_WON with games_l=1 -> score 0001000, games_l=0, match_over=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/match_scorer.sv
// Tug-of-war match scorer: a light bar tracks who is ahead, and the module
// counts games per player. Optional feature macro: FAVOR_LOSER_EN.
module match_scorer #(
    parameter int DEPTH        = 3,
    parameter int GAMES_TO_WIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               winrnd,
    input  logic               right,
    input  logic               leds_on,
    input  logic               new_game,
    output logic [2*DEPTH:0]   score,
    output logic [3:0]         games_l,
    output logic [3:0]         games_r,
    output logic               win_l,
    output logic               win_r,
    output logic               match_over
);

    localparam int BAR_W = 2 * DEPTH + 1;
    localparam logic signed [3:0] POS_MAX = 4'(DEPTH);
    localparam logic signed [3:0] POS_MIN = 4'(-DEPTH);
    localparam logic [3:0]        GTW     = 4'(GAMES_TO_WIN);

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        GAME_WON   = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    state_t             state_q;
    logic signed [3:0]  pos_q;
    logic [3:0]         games_l_q;
    logic [3:0]         games_r_q;
    logic               win_l_q;
    logic               win_r_q;
    logic               winner_right_q;

    logic               move_right;
    logic               at_right;
    logic               at_left;
    logic               win_right_ev;
    logic               win_left_ev;
    logic signed [3:0]  pos_d;

    always_comb begin
        move_right   = (right & leds_on) | (~right & ~leds_on);
        at_right     = (pos_q == POS_MAX);
        at_left      = (pos_q == POS_MIN);
        win_right_ev = at_right & move_right;
        win_left_ev  = at_left & ~move_right;
        pos_d        = move_right ? pos_q + 4'sd1 : pos_q - 4'sd1;
`ifdef FAVOR_LOSER_EN
        // A clean push by the trailing player snaps the marker back next to neutral.
        if (leds_on && right && at_left)
            pos_d = -4'sd1;
        else if (leds_on && !right && at_right)
            pos_d = 4'sd1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= PLAY;
            pos_q          <= '0;
            games_l_q      <= '0;
            games_r_q      <= '0;
            win_l_q        <= 1'b0;
            win_r_q        <= 1'b0;
            winner_right_q <= 1'b0;
        end else begin
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (new_game) begin
                        pos_q <= '0;
                    end else if (winrnd) begin
                        if (win_right_ev) begin
                            games_r_q      <= games_r_q + 4'd1;
                            win_r_q        <= 1'b1;
                            winner_right_q <= 1'b1;
                            state_q        <= (games_r_q + 4'd1 == GTW) ? MATCH_OVER : GAME_WON;
                        end else if (win_left_ev) begin
                            games_l_q      <= games_l_q + 4'd1;
                            win_l_q        <= 1'b1;
                            winner_right_q <= 1'b0;
                            state_q        <= (games_l_q + 4'd1 == GTW) ? MATCH_OVER : GAME_WON;
                        end else begin
                            pos_q <= pos_d;
                        end
                    end
                end
                GAME_WON: begin
                    if (new_game) begin
                        pos_q   <= '0;
                        state_q <= PLAY;
                    end
                end
                MATCH_OVER: begin
                end
                default: begin
                    pos_q   <= '0;
                    state_q <= PLAY;
                end
            endcase
        end
    end

    logic [4:0]       bar_idx;
    logic [BAR_W-1:0] play_bar;
    logic [BAR_W-1:0] left_bar;
    logic [BAR_W-1:0] right_bar;
    logic [BAR_W-1:0] alt_bar;

    assign bar_idx = 5'(DEPTH) - {pos_q[3], pos_q};

    genvar gi;
    generate
        for (gi = 0; gi < BAR_W; gi++) begin : g_bar
            assign play_bar[gi]  = (bar_idx == 5'(gi));
            assign left_bar[gi]  = (gi > DEPTH);
            assign right_bar[gi] = (gi < DEPTH);
            assign alt_bar[gi]   = ((gi % 2) == 0);
        end
    endgenerate

    always_comb begin
        score = alt_bar;
        case (state_q)
            PLAY:                 score = play_bar;
            GAME_WON, MATCH_OVER: score = winner_right_q ? right_bar : left_bar;
            default:              score = alt_bar;
        endcase
    end

    assign match_over = (state_q == MATCH_OVER);
    assign games_l    = games_l_q;
    assign games_r    = games_r_q;
    assign win_l      = win_l_q;
    assign win_r      = win_r_q;

endmodule
